// File: rtl/simplez_ctrl.sv
// simplez_ctrl: control unit for the Simplez processor.
// Decodes the opcode held in RI[11:9] and drives the datapath microorders
// through FETCH / DECODE / EXEC / SYNC. It also supports run/single-step
// gating for board debugging and keeps a sticky stop flag set by HALT.
//
// Ports:
//   clk        - system clock, rising edge
//   rstn_ini   - asynchronous active-low reset
//   co         - opcode RI[11:9] (ST=0 LD=1 ADD=2 BR=3 BZ=4 CLR=5 DEC=6 HALT=7)
//   a_zero     - accumulator equals zero (combinational from datapath)
//   run        - level, execute continuously when AUTORUN=0
//   step       - pulse, executes one instruction while paused in SYNC
//   cp_inc     - CP <= CP+1
//   cp_load    - CP <= CD
//   cp_sel     - memory address from CP (1) or CD (0)
//   ri_load    - RI <= mem_dout
//   a_load     - A <= source chosen by a_sel
//   a_sel      - 0 mem_dout, 1 A+mem_dout, 2 zero, 3 A-1
//   mem_we     - write A to M[CD]
//   instr_done - one-cycle pulse on the last cycle of each instruction
//   stop       - registered, set by HALT, cleared only by reset
module simplez_ctrl #(
  parameter bit AUTORUN = 1'b1
) (
  input  logic       clk,
  input  logic       rstn_ini,
  input  logic [2:0] co,
  input  logic       a_zero,
  input  logic       run,
  input  logic       step,
  output logic       cp_inc,
  output logic       cp_load,
  output logic       cp_sel,
  output logic       ri_load,
  output logic       a_load,
  output logic [1:0] a_sel,
  output logic       mem_we,
  output logic       instr_done,
  output logic       stop
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_SYNC   = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OP_ST   = 3'd0,
    OP_LD   = 3'd1,
    OP_ADD  = 3'd2,
    OP_BR   = 3'd3,
    OP_BZ   = 3'd4,
    OP_CLR  = 3'd5,
    OP_DEC  = 3'd6,
    OP_HALT = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    ASEL_MEM  = 2'd0,
    ASEL_ADD  = 2'd1,
    ASEL_ZERO = 2'd2,
    ASEL_DEC  = 2'd3
  } asel_t;

  state_t  r_state;
  state_t  w_next;
  logic    r_stop;
  logic    r_sync_first;
  logic    w_sync_go;
  logic    w_halt_decode;
  opcode_t w_op;

  assign w_op          = opcode_t'(co);
  assign w_sync_go     = AUTORUN || run || step;
  assign w_halt_decode = (r_state == S_DECODE) && (w_op == OP_HALT);
  assign stop          = r_stop;

  always_ff @(posedge clk or negedge rstn_ini) begin
    if (!rstn_ini) begin
      r_state      <= S_INIT;
      r_stop       <= 1'b0;
      r_sync_first <= 1'b0;
    end else begin
      r_state      <= w_next;
      // Marks the first SYNC cycle so instr_done is not repeated while paused.
      r_sync_first <= (w_next == S_SYNC) && (r_state != S_SYNC);
      if (w_halt_decode) begin
        r_stop <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    cp_inc     = 1'b0;
    cp_load    = 1'b0;
    cp_sel     = 1'b1;
    ri_load    = 1'b0;
    a_load     = 1'b0;
    a_sel      = ASEL_MEM;
    mem_we     = 1'b0;
    instr_done = 1'b0;

    case (r_state)
      S_INIT: begin
        w_next = S_FETCH;
      end

      S_FETCH: begin
        ri_load = 1'b1;
        w_next  = S_DECODE;
      end

      S_DECODE: begin
        case (w_op)
          OP_ST: begin
            cp_sel = 1'b0;
            mem_we = 1'b1;
            cp_inc = 1'b1;
            w_next = S_SYNC;
          end
          OP_LD, OP_ADD: begin
            cp_sel = 1'b0;
            w_next = S_EXEC;
          end
          OP_BR: begin
            cp_load = 1'b1;
            w_next  = S_SYNC;
          end
          OP_BZ: begin
            if (a_zero) begin
              cp_load = 1'b1;
            end else begin
              cp_inc = 1'b1;
            end
            w_next = S_SYNC;
          end
          OP_CLR: begin
            a_load = 1'b1;
            a_sel  = ASEL_ZERO;
            cp_inc = 1'b1;
            w_next = S_SYNC;
          end
          OP_DEC: begin
            a_load = 1'b1;
            a_sel  = ASEL_DEC;
            cp_inc = 1'b1;
            w_next = S_SYNC;
          end
          default: begin
            instr_done = 1'b1;
            w_next     = S_HALTED;
          end
        endcase
      end

      S_EXEC: begin
        cp_sel = 1'b0;
        a_load = 1'b1;
        a_sel  = (w_op == OP_ADD) ? ASEL_ADD : ASEL_MEM;
        cp_inc = 1'b1;
        w_next = S_SYNC;
      end

      S_SYNC: begin
        instr_done = r_sync_first;
        if (w_sync_go) begin
          w_next = S_FETCH;
        end
      end

      S_HALTED: begin
        w_next = S_HALTED;
      end

      default: begin
        w_next = S_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_simplez_ctrl.sv
// Directed bench for simplez_ctrl: two controllers (free-running and
// run/step gated) each drive a small Simplez datapath with its own memory.
module tb_simplez_ctrl;

  // Microorder vector: {cp_inc,cp_load,cp_sel,ri_load,a_load,a_sel,mem_we,instr_done,stop}
  localparam logic [9:0] UO_IDLE  = 10'h080;
  localparam logic [9:0] UO_FETCH = 10'h0C0;
  localparam logic [9:0] UO_SYNC  = 10'h082;
  localparam logic [9:0] UO_LDDEC = 10'h000;
  localparam logic [9:0] UO_LDEX  = 10'h220;
  localparam logic [9:0] UO_ADDEX = 10'h228;
  localparam logic [9:0] UO_ST    = 10'h204;
  localparam logic [9:0] UO_HALT  = 10'h082;
  localparam logic [9:0] UO_HLTD  = 10'h081;
  localparam logic [9:0] UO_CLR   = 10'h2B0;
  localparam logic [9:0] UO_DEC   = 10'h2B8;
  localparam logic [9:0] UO_JMP   = 10'h180;
  localparam logic [9:0] UO_BZNT  = 10'h280;

  localparam logic [9:0] P1_EXP [13] = '{
    UO_LDDEC, UO_LDEX, UO_SYNC, UO_FETCH, UO_LDDEC, UO_ADDEX, UO_SYNC,
    UO_FETCH, UO_ST, UO_SYNC, UO_FETCH, UO_HALT, UO_HLTD};
  localparam logic [9:0] P2_EXP [12] = '{
    UO_FETCH, UO_CLR, UO_SYNC, UO_FETCH, UO_DEC, UO_SYNC,
    UO_FETCH, UO_BZNT, UO_SYNC, UO_FETCH, UO_HALT, UO_HLTD};
  localparam logic [9:0] P3_EXP [5] = '{
    UO_FETCH, UO_CLR, UO_SYNC, UO_FETCH, UO_JMP};

  logic clk = 1'b0;
  logic rstn_ini = 1'b0;
  logic run = 1'b0;
  logic step = 1'b0;

  logic [1:0] cp_inc_s, cp_load_s, cp_sel_s, ri_load_s, a_load_s, mem_we_s, done_s, stop_s;
  logic [1:0] a_sel_s [2];
  logic [2:0] co_s [2];
  logic [1:0] az_s;
  logic [8:0] addr_w [2];

  logic [11:0] mem [2][512];
  logic [11:0] dout_r [2];
  logic [11:0] ri_r [2];
  logic [11:0] a_r [2];
  logic [8:0]  cp_r [2];
  logic [8:0]  pa_r [2];
  logic [8:0]  fa_r [2];
  logic [1:0]  f1_r;

  logic        clr_mem = 1'b0;
  logic        ld_en = 1'b0;
  int          ld_k = 0;
  logic [8:0]  ld_addr = '0;
  logic [11:0] ld_data = '0;

  int n_checks = 0;
  int n_fail = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  simplez_ctrl #(.AUTORUN(1)) u_dut_auto (
    .clk(clk), .rstn_ini(rstn_ini), .co(co_s[0]), .a_zero(az_s[0]),
    .run(run), .step(step), .cp_inc(cp_inc_s[0]), .cp_load(cp_load_s[0]),
    .cp_sel(cp_sel_s[0]), .ri_load(ri_load_s[0]), .a_load(a_load_s[0]),
    .a_sel(a_sel_s[0]), .mem_we(mem_we_s[0]), .instr_done(done_s[0]),
    .stop(stop_s[0]));

  simplez_ctrl #(.AUTORUN(0)) u_dut_step (
    .clk(clk), .rstn_ini(rstn_ini), .co(co_s[1]), .a_zero(az_s[1]),
    .run(run), .step(step), .cp_inc(cp_inc_s[1]), .cp_load(cp_load_s[1]),
    .cp_sel(cp_sel_s[1]), .ri_load(ri_load_s[1]), .a_load(a_load_s[1]),
    .a_sel(a_sel_s[1]), .mem_we(mem_we_s[1]), .instr_done(done_s[1]),
    .stop(stop_s[1]));

  assign co_s[0]   = ri_r[0][11:9];
  assign co_s[1]   = ri_r[1][11:9];
  assign az_s[0]   = (a_r[0] == 12'h000);
  assign az_s[1]   = (a_r[1] == 12'h000);
  assign addr_w[0] = cp_sel_s[0] ? cp_r[0] : ri_r[0][8:0];
  assign addr_w[1] = cp_sel_s[1] ? cp_r[1] : ri_r[1][8:0];

  // Memory with synchronous 1-cycle read; not cleared by processor reset.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (clr_mem) begin
        for (int i = 0; i < 512; i++) mem[k][i] <= '0;
      end else if (ld_en && ld_k == k) begin
        mem[k][ld_addr] <= ld_data;
      end else if (mem_we_s[k]) begin
        mem[k][ri_r[k][8:0]] <= a_r[k];
      end
      dout_r[k] <= mem[k][addr_w[k]];
    end
  end

  // CP / RI / A registers plus fetch-address tracking.
  always @(posedge clk or negedge rstn_ini) begin
    if (!rstn_ini) begin
      for (int k = 0; k < 2; k++) begin
        cp_r[k] <= '0;
        ri_r[k] <= '0;
        a_r[k]  <= '0;
        pa_r[k] <= '0;
        fa_r[k] <= '0;
      end
      f1_r <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        pa_r[k] <= addr_w[k];
        if (ri_load_s[k]) begin
          ri_r[k] <= dout_r[k];
          fa_r[k] <= pa_r[k];
          if (pa_r[k] == 9'd1) f1_r[k] <= 1'b1;
        end
        if (cp_load_s[k]) cp_r[k] <= ri_r[k][8:0];
        else if (cp_inc_s[k]) cp_r[k] <= cp_r[k] + 9'd1;
        if (a_load_s[k]) begin
          case (a_sel_s[k])
            2'd0: a_r[k] <= dout_r[k];
            2'd1: a_r[k] <= a_r[k] + dout_r[k];
            2'd2: a_r[k] <= '0;
            default: a_r[k] <= a_r[k] - 12'd1;
          endcase
        end
      end
    end
  end

  function automatic logic [9:0] uo(input int k);
    return {cp_inc_s[k], cp_load_s[k], cp_sel_s[k], ri_load_s[k], a_load_s[k],
            a_sel_s[k], mem_we_s[k], done_s[k], stop_s[k]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc_cnt(input int k);
    cyc();
    if (done_s[k]) n_done++;
  endtask

  task automatic do_reset();
    rstn_ini = 1'b0;
    run      = 1'b0;
    step     = 1'b0;
    clr_mem  = 1'b1;
    @(negedge clk);
    clr_mem  = 1'b0;
    chk("rst_uo_auto", 32'(uo(0)), 32'(UO_IDLE));
    chk("rst_uo_step", 32'(uo(1)), 32'(UO_IDLE));
  endtask

  task automatic load(input int k, input int addr, input logic [11:0] d);
    ld_en   = 1'b1;
    ld_k    = k;
    ld_addr = 9'(addr);
    ld_data = d;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  initial begin
    // Program 1: LD 10; ADD 11; ST 12; HALT, first interrupted in EXEC by reset.
    do_reset();
    load(0, 0, 12'h20A);
    load(0, 1, 12'h40B);
    load(0, 2, 12'h00C);
    load(0, 3, 12'hE00);
    load(0, 10, 12'd3);
    load(0, 11, 12'd4);
    rstn_ini = 1'b1;
    cyc(); chk("p1a_fetch", 32'(uo(0)), 32'(UO_FETCH));
    cyc(); chk("p1a_decode", 32'(uo(0)), 32'(UO_LDDEC));
    cyc(); chk("p1a_exec", 32'(uo(0)), 32'(UO_LDEX));
    rstn_ini = 1'b0;
    #1;
    chk("rst_mid_exec_uo", 32'(uo(0)), 32'(UO_IDLE));
    @(negedge clk);
    chk("rst_mid_exec_a", 32'(a_r[0]), 32'h0);
    rstn_ini = 1'b1;
    n_done = 0;
    cyc_cnt(0); chk("fetch_after_rst", 32'(uo(0)), 32'(UO_FETCH));
    for (int i = 0; i < 13; i++) begin
      cyc_cnt(0);
      chk($sformatf("p1_c%0d", i), 32'(uo(0)), 32'(P1_EXP[i]));
    end
    chk("p1_m12", 32'(mem[0][12]), 32'd7);
    chk("p1_a", 32'(a_r[0]), 32'd7);
    chk("p1_stop", 32'(stop_s[0]), 32'd1);
    chk("p1_done_cnt", 32'(n_done), 32'd4);

    // Program 2: CLR; DEC; BZ 0; HALT -> branch not taken.
    do_reset();
    load(0, 0, 12'hA00);
    load(0, 1, 12'hC00);
    load(0, 2, 12'h800);
    load(0, 3, 12'hE00);
    rstn_ini = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk($sformatf("p2_c%0d", i), 32'(uo(0)), 32'(P2_EXP[i]));
    end
    chk("p2_a", 32'(a_r[0]), 32'hFFF);
    chk("p2_cp", 32'(cp_r[0]), 32'd3);
    chk("p2_halt_addr", 32'(fa_r[0]), 32'd3);
    chk("p2_stop", 32'(stop_s[0]), 32'd1);

    // Program 2b: CLR; BZ 5 -> branch taken.
    do_reset();
    load(0, 0, 12'hA00);
    load(0, 1, 12'h805);
    load(0, 5, 12'hE00);
    rstn_ini = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("p2b_c%0d", i), 32'(uo(0)), 32'(P3_EXP[i]));
    end
    cyc(); chk("p2b_sync", 32'(uo(0)), 32'(UO_SYNC));
    chk("p2b_cp", 32'(cp_r[0]), 32'd5);
    cyc(); cyc(); cyc();
    chk("p2b_halted", 32'(uo(0)), 32'(UO_HLTD));
    chk("p2b_halt_addr", 32'(fa_r[0]), 32'd5);

    // Program 3: BR 7 at 0, HALT at 7; address 1 must not be fetched.
    do_reset();
    load(0, 0, 12'h607);
    load(0, 1, 12'hC00);
    load(0, 7, 12'hE00);
    rstn_ini = 1'b1;
    cyc(); chk("p3_fetch", 32'(uo(0)), 32'(UO_FETCH));
    cyc(); chk("p3_br", 32'(uo(0)), 32'(UO_JMP));
    cyc(); chk("p3_sync", 32'(uo(0)), 32'(UO_SYNC));
    chk("p3_cp", 32'(cp_r[0]), 32'd7);
    cyc(); chk("p3_fetch2", 32'(uo(0)), 32'(UO_FETCH));
    cyc(); chk("p3_halt", 32'(uo(0)), 32'(UO_HALT));
    cyc(); chk("p3_halted", 32'(uo(0)), 32'(UO_HLTD));
    chk("p3_fetch_addr", 32'(fa_r[0]), 32'd7);
    chk("p3_no_addr1", 32'(f1_r[0]), 32'd0);

    // HALTED ignores run/step.
    for (int i = 0; i < 20; i++) begin
      run  = 1'((i >> 0) & 1);
      step = 1'((i >> 1) & 1);
      cyc();
      chk($sformatf("halted_c%0d", i), 32'(uo(0)), 32'(UO_HLTD));
    end
    chk("halted_cp", 32'(cp_r[0]), 32'd7);

    // Gated controller: CLR runs to SYNC, then step x3, then run.
    do_reset();
    load(1, 0, 12'hA00);
    load(1, 1, 12'hC00);
    load(1, 2, 12'hC00);
    load(1, 3, 12'hC00);
    load(1, 4, 12'hC00);
    load(1, 5, 12'hC00);
    load(1, 6, 12'hE00);
    rstn_ini = 1'b1;
    cyc(); chk("s_fetch", 32'(uo(1)), 32'(UO_FETCH));
    cyc(); chk("s_clr", 32'(uo(1)), 32'(UO_CLR));
    cyc(); chk("s_sync", 32'(uo(1)), 32'(UO_SYNC));
    cyc(); chk("s_pause0", 32'(uo(1)), 32'(UO_IDLE));
    cyc(); chk("s_pause1", 32'(uo(1)), 32'(UO_IDLE));
    chk("s_cp0", 32'(cp_r[1]), 32'd1);
    n_done = 0;
    step = 1'b1;
    cyc_cnt(1); chk("s1_fetch", 32'(uo(1)), 32'(UO_FETCH));
    step = 1'b0;
    cyc_cnt(1); chk("s1_dec", 32'(uo(1)), 32'(UO_DEC));
    step = 1'b1;
    cyc_cnt(1); chk("s1_sync", 32'(uo(1)), 32'(UO_SYNC));
    step = 1'b0;
    cyc_cnt(1); chk("s1_step_in_decode_ignored", 32'(uo(1)), 32'(UO_IDLE));
    chk("s1_cp", 32'(cp_r[1]), 32'd2);
    step = 1'b1;
    cyc_cnt(1);
    step = 1'b0;
    cyc_cnt(1); cyc_cnt(1); cyc_cnt(1);
    chk("s2_pause", 32'(uo(1)), 32'(UO_IDLE));
    chk("s2_cp", 32'(cp_r[1]), 32'd3);
    step = 1'b1;
    cyc_cnt(1);
    step = 1'b0;
    cyc_cnt(1); cyc_cnt(1); cyc_cnt(1);
    chk("s3_pause", 32'(uo(1)), 32'(UO_IDLE));
    chk("s3_cp", 32'(cp_r[1]), 32'd4);
    chk("s3_a", 32'(a_r[1]), 32'hFFD);
    chk("s_done_cnt", 32'(n_done), 32'd3);

    run = 1'b1;
    cyc(); chk("r_fetch", 32'(uo(1)), 32'(UO_FETCH));
    cyc(); chk("r_dec", 32'(uo(1)), 32'(UO_DEC));
    cyc(); chk("r_sync", 32'(uo(1)), 32'(UO_SYNC));
    cyc(); chk("r_fetch2", 32'(uo(1)), 32'(UO_FETCH));
    run = 1'b0;
    cyc(); chk("r_dec2", 32'(uo(1)), 32'(UO_DEC));
    cyc(); chk("r_sync2", 32'(uo(1)), 32'(UO_SYNC));
    cyc(); chk("r_pause", 32'(uo(1)), 32'(UO_IDLE));
    chk("r_cp", 32'(cp_r[1]), 32'd6);
    chk("r_a", 32'(a_r[1]), 32'hFFB);
    chk("r_stop_clear", 32'(stop_s[1]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simplez_ctrl.md
# simplez_ctrl

Full control unit for the Simplez processor: it decodes the 3-bit opcode in the instruction register and sequences the existing datapath (CP, RI, accumulator, memory address mux, memory write) through every instruction: ST, LD, ADD, BR, BZ, CLR, DEC and HALT. It sits between the instruction register and the datapath registers inside the processor top level. It adds run/single-step control for board debugging and a sticky stop flag.

## Interface
- `AUTORUN`, default 1: when 1, `run` is ignored and the controller free-runs; when 0, execution is gated by `run`/`step`.
- `clk` in 1: system clock, all state changes on the rising edge.
- `rstn_ini` in 1: reset, asynchronous, active-low.
- `co` in 3: opcode field RI[11:9]. Encoding: ST=0, LD=1, ADD=2, BR=3, BZ=4, CLR=5, DEC=6, HALT=7.
- `a_zero` in 1: accumulator equals 0. Driven combinationally by the datapath.
- `run` in 1: level; 1 = execute continuously.
- `step` in 1: single-cycle pulse; executes one instruction while paused.
- `cp_inc` out 1: CP <= CP+1.
- `cp_load` out 1: CP <= CD.
- `cp_sel` out 1: memory address from CP when 1, from CD when 0.
- `ri_load` out 1: RI <= mem_dout.
- `a_load` out 1: A <= selected source.
- `a_sel` out 2: accumulator source. 0 = mem_dout, 1 = A+mem_dout (12-bit, carry discarded), 2 = zero, 3 = A−1 (12-bit wrap, 0 → 0xFFF).
- `mem_we` out 1: write A to M[CD] at this edge.
- `instr_done` out 1: one-cycle pulse, the last cycle of each instruction.
- `stop` out 1: registered; set by HALT.

## Operation
- The memory read is synchronous with 1-cycle latency. The address presented in cycle N gives data in cycle N+1.
- Microorders are combinational from the state and `co`. Unless a state specifies otherwise, the defaults are: `cp_sel=1`, all other microorders 0, `a_sel=0`.
- **INIT**: unconditionally goes to FETCH. CP is presented to memory.
- **FETCH**: `ri_load=1`, then goes to DECODE.
- **DECODE**: `co` is valid. Behaviour by opcode:
  - ST: `cp_sel=0`, `mem_we=1`, `cp_inc=1`, then SYNC.
  - LD/ADD: `cp_sel=0` (reads M[CD]), then EXEC.
  - BR: `cp_load=1`, then SYNC.
  - BZ: if `a_zero`, `cp_load=1`; else `cp_inc=1`. Then SYNC.
  - CLR: `a_load=1`, `a_sel=2`, `cp_inc=1`, then SYNC.
  - DEC: `a_load=1`, `a_sel=3`, `cp_inc=1`, then SYNC.
  - HALT: `instr_done=1`, then HALTED.
- **EXEC** (LD/ADD only): `cp_sel=0`, `a_load=1`, `a_sel` = 0 for LD or 1 for ADD, `cp_inc=1`, then SYNC.
- **SYNC**: `cp_sel=1`, which presents the new CP to memory. `instr_done=1` only on the first cycle spent in SYNC after an instruction. Exit rule:
  - If `AUTORUN=1`, or `run=1`, or `step=1`, go to FETCH.
  - Otherwise remain in SYNC (paused). While paused, all microorders are 0 except `cp_sel=1`.
- **HALTED**: terminal. All microorders are 0 except `cp_sel=1`. `stop=1`. Only reset exits.
- `stop` is set on the edge leaving DECODE with `co=HALT`. It is cleared only by reset.

## Timing
- Reset (asynchronous assert) forces: state=INIT, `stop=0`, `cp_sel=1`, all other outputs 0. This happens immediately, including mid-instruction; partially executed instructions are abandoned.
- Deassertion is synchronous to the first rising edge after `rstn_ini` rises. The first FETCH follows INIT by 1 cycle.
- Instruction cycle counts (FETCH through SYNC inclusive):
  - ST, BR, BZ, CLR, DEC: 3 cycles.
  - LD, ADD: 4 cycles.
  - HALT: 2 cycles to HALTED.
- `a_zero` is sampled only in DECODE for BZ. It reflects A before the instruction executes.
- In ST, `mem_we` coincides with `cp_sel=0`, so the address is CD and the data written is the current A.
- `step` is honoured only while in SYNC. A pulse in any other state is ignored and is not stored. If `step` stays high N cycles in SYNC, each SYNC visit proceeds, so 1 instruction executes per SYNC visit.
- `run` and `step` high together behaves as `run`.
- Dropping `run` mid-instruction completes the current instruction, then pauses in SYNC.
- Under `AUTORUN=1`, SYNC lasts exactly 1 cycle.

## Test plan
- Reset mid-EXEC of LD: assert `rstn_ini`=0 in EXEC. Required: state INIT immediately, `a_load`=0, `stop`=0. After release, FETCH occurs 1 cycle later.
- Program `LD 10; ADD 11; ST 12; HALT` with M[10]=3, M[11]=4: M[12]=7, `stop`=1 after 4+4+3+2 cycles from the first FETCH, and `instr_done` pulses exactly 4 times.
- `CLR; DEC; BZ 0; HALT`: A=0xFFF and the BZ branch is not taken (CP=3). Then with a fresh program `CLR; BZ 5`, CP=5 on the cycle after DECODE.
- `BR 7` at address 0 with HALT at 7: `cp_load`=1 in DECODE, next FETCH reads address 7, `stop`=1. Address 1 is never fetched.
- `AUTORUN=0`, `run`=0: the controller sits in SYNC. Three `step` pulses execute exactly 3 instructions, CP advances 3, and a step pulse sent during DECODE has no effect.
- In HALTED, toggle `run`/`step` for 20 cycles: outputs unchanged (`cp_sel`=1, the rest 0, `stop`=1).
